// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the performance-counter dump path:
// counter width, counter index map and the dump sequencer state encoding.
package VX_gpu_pkg;

  localparam int PERF_CTR_BITS = 44;

  localparam int PERF_IDX_SCHED_IDLES   = 0;
  localparam int PERF_IDX_SCHED_STALLS  = 1;
  localparam int PERF_IDX_IBF_STALLS    = 2;
  localparam int PERF_IDX_SCB_STALLS    = 3;
  localparam int PERF_IDX_IFETCHES      = 4;
  localparam int PERF_IDX_LOADS         = 5;
  localparam int PERF_IDX_STORES        = 6;
  localparam int PERF_IDX_IFETCH_LAT    = 7;
  localparam int PERF_IDX_LOAD_LAT      = 8;
  localparam int PERF_IDX_ACTIVE_WARPS  = 9;
  localparam int PERF_IDX_STALLED_WARPS = 10;
  localparam int PERF_NUM_CTRS          = 11;

  typedef enum logic [1:0] {
    PERF_DUMP_IDLE   = 2'd0,
    PERF_DUMP_STREAM = 2'd1,
    PERF_DUMP_DONE   = 2'd2
  } perf_dump_state_e;

  function automatic int perf_log2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_priority_encoder.sv
// Lowest-index-first priority encoder: one-hot, binary index and any-set flag.
module VX_priority_encoder #(
  parameter int N  = 4,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [N-1:0]  onehot_out,
  output logic [LN-1:0] index_out,
  output logic          valid_out
);

  always_comb begin
    onehot_out = '0;
    index_out  = '0;
    valid_out  = |data_in;
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (data_in[i]) begin
        onehot_out = N'(1) << i;
        index_out  = LN'(i);
      end
    end
  end

endmodule

// File: rtl/vx_perf_dump_ctrl.sv
// Performance-counter dump sequencer: snapshots the counter bundles of the
// selected cores on request and streams them one counter per beat.
module vx_perf_dump_ctrl
  import VX_gpu_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_CTRS  = PERF_NUM_CTRS,
  parameter int CTR_BITS  = PERF_CTR_BITS,
  parameter int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int IW        = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CORES*NUM_CTRS*CTR_BITS-1:0] ctr_in,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [NUM_CORES-1:0]               req_mask,
  input  logic                               req_delta,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CW-1:0]                      out_core,
  output logic [IW-1:0]                      out_idx,
  output logic [CTR_BITS-1:0]                out_data,
  output logic                               out_last,
  output logic                               done,
  output perf_dump_state_e                   dbg_state
);

  // Handshake: a request transfers on req_valid && req_ready, a beat on
  // out_valid && out_ready; once out_valid is high the beat fields hold
  // steady and out_valid stays high until that beat transfers.

  perf_dump_state_e state_q, state_d;
  logic [NUM_CORES-1:0] rem_q, rem_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [CTR_BITS-1:0] ctr_live [NUM_CORES][NUM_CTRS];
  logic [CTR_BITS-1:0] snap_q   [NUM_CORES][NUM_CTRS];
  logic [CTR_BITS-1:0] base_q   [NUM_CORES][NUM_CTRS];

  logic [NUM_CORES-1:0] cur_oh;
  logic [NUM_CORES-1:0] rem_after;
  logic [CW-1:0]        cur_core;
  logic                 cur_any;
  logic                 idx_last;
  logic                 beat_last;
  logic                 accept;

  VX_priority_encoder #(
    .N  (NUM_CORES),
    .LN (CW)
  ) u_core_sel (
    .data_in    (rem_q),
    .onehot_out (cur_oh),
    .index_out  (cur_core),
    .valid_out  (cur_any)
  );

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_live[c][i] = ctr_in[(c*NUM_CTRS+i)*CTR_BITS +: CTR_BITS];
      end
    end
  end

  assign accept    = req_valid && req_ready;
  assign idx_last  = (idx_q == IW'(NUM_CTRS - 1));
  assign rem_after = rem_q & ~cur_oh;
  assign beat_last = idx_last && (rem_after == '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    unique case (state_q)
      PERF_DUMP_IDLE: begin
        if (req_valid) begin
          rem_d   = req_mask;
          idx_d   = '0;
          state_d = (req_mask != '0) ? PERF_DUMP_STREAM : PERF_DUMP_DONE;
        end
      end
      PERF_DUMP_STREAM: begin
        if (out_ready) begin
          if (idx_last) begin
            idx_d = '0;
            rem_d = rem_after;
            if (rem_after == '0) state_d = PERF_DUMP_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PERF_DUMP_DONE: state_d = PERF_DUMP_IDLE;
      default:        state_d = PERF_DUMP_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == PERF_DUMP_IDLE);
    done      = (state_q == PERF_DUMP_DONE);
    out_valid = (state_q == PERF_DUMP_STREAM) && cur_any;
    out_core  = '0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_core = cur_core;
      out_idx  = idx_q;
      out_data = snap_q[cur_core][idx_q];
      out_last = beat_last;
    end
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PERF_DUMP_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  // Deltas are formed at capture time against the base being replaced, so
  // the streamed value is a plain register read and base can move on at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int i = 0; i < NUM_CTRS; i++) begin
          snap_q[c][i] <= '0;
          base_q[c][i] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (req_mask[c]) begin
          for (int i = 0; i < NUM_CTRS; i++) begin
            if (req_delta) begin
              snap_q[c][i] <= ctr_live[c][i] - base_q[c][i];
              base_q[c][i] <= ctr_live[c][i];
            end else begin
              snap_q[c][i] <= ctr_live[c][i];
            end
          end
        end
      end
    end
  end

endmodule
